// File: rtl/if_else_share_pkg.sv
// Shared types and default constants for the if/else datapath sharing controller.
package if_else_share_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DP_LATENCY = 3;
    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W       = 3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/if_else_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first active request at or above ptr (with wrap).
module rr_arbiter
    import if_else_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    ptr
);

    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] gnt_idx_s;
    logic [ID_W-1:0] ptr_nxt_s;
    logic [ID_W:0]   idx_s;
    logic            found_s;

    // Search upward from the pointer, wrapping at NUM_REQ.
    always_comb begin
        gnt       = '0;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req[idx_s[ID_W-1:0]]) begin
                found_s                 = 1'b1;
                gnt[idx_s[ID_W-1:0]]    = 1'b1;
                gnt_idx_s               = idx_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer moves just past the winner.
    always_comb begin
        if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_idx_s + ID_W'(1);
        end
    end

    // Pointer register, updated only on a completed handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/if_else_share_ctrl.sv
// Shares one fixed-latency if/else datapath between NUM_REQ requesters, with
// round-robin issue, an id tag pipe for response routing, and a flush/drain mode.
module if_else_share_ctrl
    import if_else_share_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DP_LATENCY = DEF_DP_LATENCY,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      dp_vld,
    output logic [DATA_W-1:0]         dp_a,
    output logic [DATA_W-1:0]         dp_b,
    input  logic [DATA_W-1:0]         dp_result,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      busy
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NUM_REQ-1:0]  arb_req_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [ID_W-1:0]     ptr_s;
    logic [ID_W-1:0]     gnt_id_s;
    logic                hs_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [ID_W-1:0]     dp_id_r;
    tag_t                tag_r [DP_LATENCY];
    logic                tags_busy_s;
    logic                busy_s;
    // Pointer is kept visible on the arbiter for debug; the top does not need it.
    logic                unused_ptr_s;

    assign unused_ptr_s = ^ptr_s;
    assign arb_req_s    = (state_r == ST_RUN) ? req_valid : '0;
    assign req_ready    = gnt_s;
    assign hs_s         = |gnt_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req_s),
        .advance (hs_s),
        .gnt     (gnt_s),
        .ptr     (ptr_s)
    );

    // Operand mux and id encode from the one-hot grant.
    always_comb begin
        sel_a_s  = '0;
        sel_b_s  = '0;
        gnt_id_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_a_s  = req_a[i*DATA_W +: DATA_W];
                sel_b_s  = req_b[i*DATA_W +: DATA_W];
                gnt_id_s = ID_W'(i);
            end else begin
                gnt_id_s = gnt_id_s;
            end
        end
    end

    // In-flight detection over the issue register and every tag stage.
    always_comb begin
        tags_busy_s = 1'b0;
        for (int k = 0; k < DP_LATENCY; k++) begin
            tags_busy_s = tags_busy_s | tag_r[k].valid;
        end
    end

    assign busy_s = dp_vld | tags_busy_s;
    assign busy   = busy_s;

    // Flush FSM next-state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) state_nxt_s = ST_DRAIN;
                else       state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (!busy_s) state_nxt_s = ST_DRAINED;
                else         state_nxt_s = ST_DRAIN;
            end
            ST_DRAINED: begin
                if (!flush) state_nxt_s = ST_RUN;
                else        state_nxt_s = ST_DRAINED;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state and registered flush_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            flush_done <= (state_nxt_s == ST_DRAINED);
        end
    end

    // Issue register; operands hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_vld  <= 1'b0;
            dp_a    <= '0;
            dp_b    <= '0;
            dp_id_r <= '0;
        end else if (hs_s) begin
            dp_vld  <= 1'b1;
            dp_a    <= sel_a_s;
            dp_b    <= sel_b_s;
            dp_id_r <= gnt_id_s;
        end else begin
            dp_vld  <= 1'b0;
        end
    end

    // Tag pipe fed from the issue register so its exit lines up with dp_result.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DP_LATENCY; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_r[0].valid <= dp_vld;
            tag_r[0].id    <= TAG_ID_W'(dp_id_r);
            for (int k = 1; k < DP_LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Response register captures the datapath result when a tag exits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (tag_r[DP_LATENCY-1].valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= ID_W'(tag_r[DP_LATENCY-1].id);
            rsp_data  <= dp_result;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/if_else_share_ctrl.md
# if_else_share_ctrl

Shares one fixed-latency `if_else_self_gen` datapath between `NUM_REQ` requesters. Requesters arrive on independent valid/ready operand ports. Grants are round-robin, with at most one issue per cycle, so the datapath runs fully pipelined. Each result is routed back to the requester that issued it. The block sits between the array-streaming front ends and the generated if/else datapath, and has a flush mode for reconfiguration or drain.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `DATA_W`, default 32: operand and result width.
- `DP_LATENCY`, default 3: cycles from `dp_vld` to a valid `dp_result`, at least 1.
- `ID_W`, default `$clog2(NUM_REQ)` (minimum 1): requester ID width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester operand valid.
- `req_ready` out `NUM_REQ`: per-requester grant, one-hot or zero.
- `req_a` in `NUM_REQ*DATA_W`: packed `a` operands; requester i uses bits [i*DATA_W +: DATA_W].
- `req_b` in `NUM_REQ*DATA_W`: packed `b` operands, same packing.
- `dp_vld` out 1: operands on `dp_a`/`dp_b` are valid this cycle.
- `dp_a` out `DATA_W`: connects to datapath `array_a_wire_0`.
- `dp_b` out `DATA_W`: connects to datapath `array_b_wire_0`.
- `dp_result` in `DATA_W`: connects from datapath `temp_combine`.
- `rsp_valid` out 1: response valid.
- `rsp_id` out `ID_W`: requester the response belongs to.
- `rsp_data` out `DATA_W`: result.
- `flush` in 1: level request to stop issuing and drain.
- `flush_done` out 1: high while in DRAINED state.
- `busy` out 1: at least one operation in flight.

## Operation
- FSM states:
  - RUN: arbitrate. Goes to DRAIN when `flush`=1.
  - DRAIN: no grants. Goes to DRAINED when the in-flight pipe is empty.
  - DRAINED: `flush_done`=1. Goes to RUN when `flush`=0.
  - If the pipe is empty when `flush` rises, DRAIN lasts exactly one cycle.
- Arbitration happens in RUN only:
  - Round-robin pointer `ptr`. Grant goes to the first requester with `req_valid`=1, searching from `ptr` upward with wrap.
  - `req_ready` is combinational from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - On a handshake by requester g, `ptr` becomes (g+1) mod `NUM_REQ`. Without a handshake, `ptr` holds.
- Issue: on a handshake, `dp_a`/`dp_b`/`dp_vld` register the granted operands. With no handshake, `dp_vld`=0 and `dp_a`/`dp_b` hold their last values.
- Tag pipe:
  - A shift register `DP_LATENCY` deep carries {valid, id}, aligned with the datapath.
  - On its exit, a valid entry registers `rsp_valid`=1, `rsp_id`=id, `rsp_data`=`dp_result`.
  - There is no response backpressure; requesters must accept the response in the cycle it appears.
- `busy` = OR of `dp_vld` and all tag-pipe valids.
- Reset values: `ptr`=0, state RUN, all tag valids 0, `dp_vld`=0, `dp_a`=`dp_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `flush_done`=0, `busy`=0.
- Reset mid-operation discards in-flight tags. No response is ever emitted for an operation issued before reset.
- `flush` asserted in the same cycle as a handshake: that handshake completes, and the operation drains normally.

## Timing
- A handshake in cycle C produces:
  - `dp_vld`=1 in C+1;
  - `dp_result` sampled in C+1+`DP_LATENCY`;
  - `rsp_valid`=1 in C+2+`DP_LATENCY`.
- Total latency is `DP_LATENCY`+2. Responses come back in issue order.
- Throughput: 1 operation per cycle sustained.
- With all requesters continuously valid, each gets exactly one grant every `NUM_REQ` cycles.
- `flush_done` rises on the cycle after the last in-flight `rsp_valid`.

## Structure
- Package `if_else_share_pkg` holds:
  - the state enum (RUN, DRAIN, DRAINED);
  - the `tag_t` struct {valid, id};
  - default constants for `NUM_REQ`, `DATA_W`, `DP_LATENCY`.
- Sub-module `rr_arbiter`:
  - parameterised on `NUM_REQ`;
  - inputs `req`, `advance`; outputs one-hot `gnt` and `ptr`;
  - pointer updates on `advance`.
- Top level holds the FSM, the operand registers, the tag pipe and the response register.

## Test plan
Bench setup: behavioural datapath model with `dp_result` = a+b, `DP_LATENCY`=3, `NUM_REQ`=2.
- Single issue: requester 0 sends a=5, b=7 in cycle 10 -> `dp_vld` in 11; `rsp_valid`=1 in 15 with `rsp_id`=0, `rsp_data`=12; `busy` high for cycles 11-14.
- Contention: both requesters valid for 6 cycles from reset -> grants 0,1,0,1,0,1; responses in the same order, 5 cycles after each grant.
- Pointer hold: only requester 1 valid for 3 cycles, then both valid -> grants 1,1,1, then 0, then 1.
- Flush: `flush` raised the cycle after 3 back-to-back issues -> `req_ready`=0 thereafter; all 3 responses delivered; `flush_done`=1 the cycle after the third `rsp_valid`; grants resume the cycle after `flush` drops.
- Reset mid-flight: 2 operations issued, `reset` pulsed 2 cycles later -> no `rsp_valid` ever appears for them; all outputs take reset values; the next issue gets grant to requester 0.
- Wrap and width: a=0xFFFF_FFFF, b=1 -> `rsp_data`=0x0000_0000, with `rsp_id` correct.
